// File: rtl/c_requant_drain_if.sv
// c_requant_drain_if
// Bundles the two buses of the requant/drain stage:
//   - C buffer read bus: C_index (read address) and C_data_out (read data,
//     valid one cycle after the address).
//   - Output stream:     out_valid / out_ready / out_data (packed int8 word).
// Modports:
//   master - the drain block (drives C_index and the output stream)
//   slave  - the environment (C buffer memory and the output writer)
interface c_requant_drain_if #(
    parameter int IDX_W = 16
);
    logic [IDX_W-1:0] C_index;
    logic [127:0]     C_data_out;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;

    modport master (
        output C_index,
        input  C_data_out,
        output out_valid,
        input  out_ready,
        output out_data
    );

    modport slave (
        input  C_index,
        output C_data_out,
        input  out_valid,
        output out_ready,
        input  out_data
    );
endinterface

// File: rtl/c_requant_drain.sv
// c_requant_drain
// Drains the C buffer after the systolic array finishes. Each 128-bit entry
// holds four int32 accumulators; each lane is requantized to int8 using the
// TFLite per-tensor fixed-point scheme, and the four bytes are streamed out
// as one 32-bit word.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid          start pulse; samples count and the quantization config
//   count             number of C entries to drain (0 allowed)
//   q_mult, q_shift   signed multiplier and right shift (0..31)
//   out_zp            signed output zero point (9 bits)
//   act_min, act_max  signed int8 clamp bounds (max applied last)
//   busy              high from the cycle after in_valid until the last
//                     word is accepted
//   bus               C buffer read bus and output stream (master side)
module c_requant_drain #(
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_W      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] count,
    input  logic [31:0] q_mult,
    input  logic [4:0]  q_shift,
    input  logic [8:0]  out_zp,
    input  logic [7:0]  act_min,
    input  logic [7:0]  act_max,
    output logic        busy,
    c_requant_drain_if.master bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_next;

    logic signed [31:0] cfg_mult;
    logic        [4:0]  cfg_shift;
    logic signed [8:0]  cfg_zp;
    logic signed [7:0]  cfg_min, cfg_max;
    logic        [15:0] rem;
    logic   [IDX_W-1:0] idx;

    logic               v_rd, v_s1, v_s2;
    logic signed [31:0] h_s1   [4];
    logic signed [31:0] h_next [4];
    logic        [31:0] word_s2, word_next;

    logic        [31:0] fifo_mem [FIFO_DEPTH];
    logic   [PTR_W-1:0] wr_ptr, rd_ptr;
    logic   [CNT_W-1:0] fill;

    logic               pop, issue, pipe_empty;
    logic       [CNT_W:0] total;

    // High half of the doubled product with round-to-nearest; the only
    // overflowing input pair saturates.
    function automatic logic signed [31:0] s1_high(input logic signed [31:0] x,
                                                   input logic signed [31:0] m);
        logic signed [63:0] xe, me, p, s, t;
        if (x == 32'sh8000_0000 && m == 32'sh8000_0000) begin
            return 32'sh7FFF_FFFF;
        end
        xe = 64'(x);
        me = 64'(m);
        p  = xe * me;
        s  = p + (p[63] ? (64'sd1 - 64'sd1073741824) : 64'sd1073741824);
        // Arithmetic shift floors; bias negatives so the divide truncates toward zero.
        t  = s[63] ? ((s + 64'sd2147483647) >>> 31) : (s >>> 31);
        return t[31:0];
    endfunction

    // Rounding right shift, zero point, then clamp (high bound wins).
    function automatic logic [7:0] s2_requant(input logic signed [31:0] h,
                                              input logic        [4:0]  sh,
                                              input logic signed [8:0]  zp,
                                              input logic signed [7:0]  lo,
                                              input logic signed [7:0]  hi);
        logic        [31:0] mask, r, thr;
        logic signed [31:0] y;
        logic signed [32:0] z;
        mask = (32'd1 << sh) - 32'd1;
        r    = h & mask;
        thr  = (mask >> 1) + {31'd0, h[31]};
        y    = (h >>> sh) + ((r > thr) ? 32'sd1 : 32'sd0);
        z    = 33'(y) + 33'(zp);
        if (z < 33'(lo)) z = 33'(lo);
        if (z > 33'(hi)) z = 33'(hi);
        return z[7:0];
    endfunction

    // Read issue: outstanding words (queued plus in flight) never exceed the
    // FIFO depth; a pop this cycle frees a slot so streaming runs at full rate.
    always_comb begin
        pop        = (fill != '0) && bus.out_ready;
        pipe_empty = !(v_rd || v_s1 || v_s2);
        total      = {1'b0, fill} + (CNT_W + 1)'(v_rd) + (CNT_W + 1)'(v_s1)
                   + (CNT_W + 1)'(v_s2);
        issue      = (state == RUN) && !in_valid && (rem != 16'd0)
                   && ((total < DEPTH_C) || pop);
    end

    // Next state. A start pulse always wins and restarts from scratch; RUN
    // with nothing left to read only happens for a count of zero.
    always_comb begin
        state_next = state;
        if (in_valid) begin
            state_next = RUN;
        end else begin
            case (state)
                IDLE:  state_next = IDLE;
                RUN: begin
                    if (rem == 16'd0) begin
                        state_next = IDLE;
                    end else if (issue && rem == 16'd1) begin
                        state_next = DRAIN;
                    end
                end
                DRAIN: begin
                    if (pipe_empty && (fill == '0 || (fill == CNT_W'(1) && pop))) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Config capture and read address generation. The address returns to 0
    // whenever the block goes idle, so a start always reads from entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_mult  <= '0;
            cfg_shift <= '0;
            cfg_zp    <= '0;
            cfg_min   <= '0;
            cfg_max   <= '0;
            rem       <= '0;
            idx       <= '0;
        end else if (in_valid) begin
            cfg_mult  <= q_mult;
            cfg_shift <= q_shift;
            cfg_zp    <= out_zp;
            cfg_min   <= act_min;
            cfg_max   <= act_max;
            rem       <= count;
            idx       <= '0;
        end else if (issue) begin
            rem <= rem - 16'd1;
            if (rem != 16'd1) begin
                idx <= idx + IDX_W'(1);
            end
        end else if (state_next == IDLE) begin
            idx <= '0;
        end
    end

    always_comb begin
        word_next = '0;
        for (int k = 0; k < 4; k++) begin
            h_next[k] = s1_high(bus.C_data_out[127 - 32*k -: 32], cfg_mult);
            word_next[31 - 8*k -: 8] = s2_requant(h_s1[k], cfg_shift, cfg_zp,
                                                  cfg_min, cfg_max);
        end
    end

    // Three-stage datapath: read data returning, S1 high-mul, S2 requant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_rd    <= 1'b0;
            v_s1    <= 1'b0;
            v_s2    <= 1'b0;
            word_s2 <= '0;
            for (int k = 0; k < 4; k++) h_s1[k] <= '0;
        end else begin
            v_rd <= issue;
            v_s1 <= v_rd && !in_valid;
            v_s2 <= v_s1 && !in_valid;
            if (v_rd) begin
                for (int k = 0; k < 4; k++) h_s1[k] <= h_next[k];
            end
            if (v_s1) begin
                word_s2 <= word_next;
            end
        end
    end

    // Output FIFO; the head entry drives out_data directly from storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else if (in_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (v_s2) begin
                fifo_mem[wr_ptr] <= word_s2;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fill <= fill + CNT_W'(v_s2) - CNT_W'(pop);
        end
    end

    assign busy          = (state != IDLE);
    assign bus.C_index   = idx;
    assign bus.out_valid = (fill != '0);
    assign bus.out_data  = fifo_mem[rd_ptr];
endmodule

// File: tb/tb_c_requant_drain.sv
// tb_c_requant_drain
// Directed bench for c_requant_drain: a table of single-entry requant
// vectors with hand-computed packed words, followed by hand-written
// sequences for backpressure, count=0, asynchronous reset and restart.
module tb_c_requant_drain;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] count;
    logic [31:0] q_mult;
    logic [4:0]  q_shift;
    logic [8:0]  out_zp;
    logic [7:0]  act_min;
    logic [7:0]  act_max;
    logic        busy;

    int vec_count   = 0;
    int miscompares = 0;

    logic [127:0] cmem [32];

    c_requant_drain_if #(.IDX_W(16)) bus ();

    c_requant_drain #(.FIFO_DEPTH(4), .IDX_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .count    (count),
        .q_mult   (q_mult),
        .q_shift  (q_shift),
        .out_zp   (out_zp),
        .act_min  (act_min),
        .act_max  (act_max),
        .busy     (busy),
        .bus      (bus)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // C buffer model: data appears one cycle after the address
    always @(posedge clk) begin
        bus.C_data_out <= cmem[bus.C_index[4:0]];
    end

    // Hard stop if a sequence ever hangs
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        string        name;
        logic [127:0] cdata;
        logic [31:0]  mult;
        logic [4:0]   shift;
        logic [8:0]   zp;
        logic [7:0]   amin;
        logic [7:0]   amax;
        logic [31:0]  expw;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives a one-cycle start pulse; returns at the negedge after it
    task automatic applyStimulus(input logic [15:0] cnt, input logic [31:0] mult,
                                 input logic [4:0] shift, input logic [8:0] zp,
                                 input logic [7:0] amin, input logic [7:0] amax);
        @(negedge clk);
        count    = cnt;
        q_mult   = mult;
        q_shift  = shift;
        out_zp   = zp;
        act_min  = amin;
        act_max  = amax;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Ramp data: lanes 2i, 2i+2, 2i+4, 2i+6 reduce to i..i+3 with q_mult=2^30
    task automatic fillRamp();
        for (int i = 0; i < 32; i++) begin
            cmem[i] = {32'(2*i), 32'(2*i + 2), 32'(2*i + 4), 32'(2*i + 6)};
        end
    endtask

    function automatic logic [31:0] expWord(input int i, input int zp);
        return {8'(i + zp), 8'(i + 1 + zp), 8'(i + 2 + zp), 8'(i + 3 + zp)};
    endfunction

    // Takes n words in order within a cycle budget, then checks busy dropped
    task automatic collectWords(input int n, input int zp, input int budget);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < budget) begin
            if (bus.out_valid && bus.out_ready) begin
                checkOutput($sformatf("word%0d", got), bus.out_data, expWord(got, zp));
                got++;
                if (got == n) checkOutput("busy_at_last", {31'd0, busy}, 32'd1);
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput("word_count", got, n);
        checkOutput("busy_fall", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic saw;

        vecs[0] = '{"scale",   {4{32'd100}}, 32'h4000_0000, 5'd0, 9'h180, 8'h80, 8'h7F, 32'hB2B2_B2B2};
        vecs[1] = '{"round",   {32'd5, 32'hFFFF_FFFB, 32'd6, 32'hFFFF_FFFA},
                    32'h7FFF_FFFF, 5'd1, 9'h000, 8'h80, 8'h7F, 32'h03FD_03FD};
        vecs[2] = '{"saturate", {32'h8000_0000, 32'd0, 32'd0, 32'd0},
                    32'h8000_0000, 5'd31, 9'h000, 8'hF6, 8'h14, 32'h0100_0000};
        vecs[3] = '{"clamp",   {32'd1000000, 32'd1000000, 32'hFFF0_BDC0, 32'd5},
                    32'h7FFF_FFFF, 5'd0, 9'h000, 8'hF6, 8'h14, 32'h1414_F605};
        vecs[4] = '{"zp_shift", {32'd1000, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FFF9},
                    32'h4000_0000, 5'd2, 9'h003, 8'h80, 8'h7F, 32'h7F86_0402};
        vecs[5] = '{"min_gt_max", {32'd0, 32'd100, 32'hFFFF_FF9C, 32'd7},
                    32'h4000_0000, 5'd0, 9'h000, 8'h0A, 8'hFB, 32'hFBFB_FBFB};
        vecs[6] = '{"neg_zp",  {32'd600, 32'd2, 32'd0, 32'hFFFF_FFFE},
                    32'h4000_0000, 5'd0, 9'h100, 8'h80, 8'h7F, 32'h2C80_8080};

        rst_n         = 1'b0;
        in_valid      = 1'b0;
        count         = '0;
        q_mult        = '0;
        q_shift       = '0;
        out_zp        = '0;
        act_min       = '0;
        act_max       = '0;
        bus.out_ready = 1'b1;
        fillRamp();

        // Reset state
        #1;
        checkOutput("rst_busy",      {31'd0, busy},          32'd0);
        checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("rst_C_index",   {16'd0, bus.C_index},   32'd0);
        checkOutput("rst_out_data",  bus.out_data,           32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single-entry vectors: latency, packed result, busy fall
        for (int v = 0; v < 7; v++) begin
            cmem[0] = vecs[v].cdata;
            applyStimulus(16'd1, vecs[v].mult, vecs[v].shift, vecs[v].zp,
                          vecs[v].amin, vecs[v].amax);
            checkOutput({vecs[v].name, "_busy"}, {31'd0, busy}, 32'd1);
            repeat (3) @(negedge clk);
            checkOutput({vecs[v].name, "_early"}, {31'd0, bus.out_valid}, 32'd0);
            @(negedge clk);
            checkOutput({vecs[v].name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
            checkOutput({vecs[v].name, "_data"}, bus.out_data, vecs[v].expw);
            @(negedge clk);
            checkOutput({vecs[v].name, "_idle"}, {31'd0, busy}, 32'd0);
            checkOutput({vecs[v].name, "_drained"}, {31'd0, bus.out_valid}, 32'd0);
        end

        // Backpressure: reads stall once four words are outstanding
        fillRamp();
        bus.out_ready = 1'b0;
        applyStimulus(16'd16, 32'h4000_0000, 5'd0, 9'h000, 8'h80, 8'h7F);
        saw = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.C_index > 16'd4) saw = 1'b1;
            @(negedge clk);
        end
        checkOutput("bp_idx_bound", {31'd0, saw},          32'd0);
        checkOutput("bp_C_index",   {16'd0, bus.C_index},  32'd4);
        checkOutput("bp_valid",     {31'd0, bus.out_valid}, 32'd1);
        checkOutput("bp_head",      bus.out_data,          expWord(0, 0));
        checkOutput("bp_busy",      {31'd0, busy},         32'd1);
        bus.out_ready = 1'b1;
        collectWords(16, 0, 200);

        // count=0: one-cycle busy, no reads, nothing output
        applyStimulus(16'd0, 32'h4000_0000, 5'd0, 9'h000, 8'h80, 8'h7F);
        checkOutput("zero_busy",    {31'd0, busy},        32'd1);
        checkOutput("zero_idx",     {16'd0, bus.C_index}, 32'd0);
        @(negedge clk);
        checkOutput("zero_busy_off", {31'd0, busy},        32'd0);
        checkOutput("zero_idx2",     {16'd0, bus.C_index}, 32'd0);
        saw = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid) saw = 1'b1;
            @(negedge clk);
        end
        checkOutput("zero_no_valid", {31'd0, saw}, 32'd0);

        // Asynchronous reset in the middle of a run
        applyStimulus(16'd16, 32'h4000_0000, 5'd0, 9'h000, 8'h80, 8'h7F);
        for (int c = 0; c < 40 && bus.C_index != 16'd7; c++) @(negedge clk);
        checkOutput("mid_reach_idx7", {16'd0, bus.C_index}, 32'd7);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy",  {31'd0, busy},          32'd0);
        checkOutput("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("mid_rst_idx",   {16'd0, bus.C_index},   32'd0);
        checkOutput("mid_rst_data",  bus.out_data,           32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (bus.out_valid || busy) saw = 1'b1;
            @(negedge clk);
        end
        checkOutput("post_rst_quiet", {31'd0, saw}, 32'd0);

        // Restart while busy: new config, index back to 0, no stale words
        applyStimulus(16'd16, 32'h4000_0000, 5'd0, 9'h000, 8'h80, 8'h7F);
        for (int c = 0; c < 40 && bus.C_index != 16'd5; c++) @(negedge clk);
        checkOutput("rs_reach_idx5", {16'd0, bus.C_index}, 32'd5);
        bus.out_ready = 1'b0;
        applyStimulus(16'd3, 32'h4000_0000, 5'd0, 9'd50, 8'h80, 8'h7F);
        checkOutput("rs_idx",   {16'd0, bus.C_index},   32'd0);
        checkOutput("rs_busy",  {31'd0, busy},          32'd1);
        checkOutput("rs_flush", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b1;
        collectWords(3, 50, 60);
        saw = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid) saw = 1'b1;
            @(negedge clk);
        end
        checkOutput("rs_no_extra", {31'd0, saw}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end
endmodule
